pong_game_ctrl: RTL and testbench

//  Parametrised Pong game engine: paddle motion, ball motion and bounce, scoring, win detection.

---
 rtl/pong_game_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// Tile-grid Pong engine: paddle motion, ball stepping and bounce, scoring and win detection.
// Produces positions, scores and game state only; drawing happens downstream.
module pong_game_ctrl #(
  parameter int GAME_WIDTH    = 40,
  parameter int GAME_HEIGHT   = 30,
  parameter int PADDLE_HEIGHT = 6,
  parameter int BALL_SPEED    = 1250000,
  parameter int PADDLE_SPEED  = 1250000,
  parameter int POINT_DELAY   = 25000000,
  parameter int SCORE_WIDTH   = 4,
  parameter int SCORE_LIMIT   = 9,
  localparam int X_W = $clog2(GAME_WIDTH),
  localparam int Y_W = $clog2(GAME_HEIGHT)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   Game_Start_i,
  input  logic                   Paddle_Up_P1_i,
  input  logic                   Paddle_Down_P1_i,
  input  logic                   Paddle_Up_P2_i,
  input  logic                   Paddle_Down_P2_i,
  output logic [X_W-1:0]         Ball_X_o,
  output logic [Y_W-1:0]         Ball_Y_o,
  output logic [Y_W-1:0]         Paddle_Y_P1_o,
  output logic [Y_W-1:0]         Paddle_Y_P2_o,
  output logic [SCORE_WIDTH-1:0] Score_P1_o,
  output logic [SCORE_WIDTH-1:0] Score_P2_o,
  output logic [1:0]             State_o,
  output logic [1:0]             Winner_o,
  output logic                   Ball_Active_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUNNING = 2'd1, POINT = 2'd2, GAME_OVER = 2'd3} state_t;

  localparam int CNT_MAX = (BALL_SPEED > POINT_DELAY) ? BALL_SPEED : POINT_DELAY;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int PCNT_W  = $clog2(PADDLE_SPEED);

  localparam logic [X_W-1:0] X_CENTRE      = X_W'(GAME_WIDTH / 2);
  localparam logic [X_W-1:0] X_NEAR_P2     = X_W'(GAME_WIDTH - 2);
  localparam logic [X_W-1:0] X_NEAR_P1     = X_W'(1);
  localparam logic [Y_W-1:0] Y_CENTRE      = Y_W'(GAME_HEIGHT / 2);
  localparam logic [Y_W-1:0] Y_BOTTOM      = Y_W'(GAME_HEIGHT - 1);
  localparam logic [Y_W-1:0] PADDLE_MAX    = Y_W'(GAME_HEIGHT - PADDLE_HEIGHT);
  localparam logic [Y_W-1:0] PADDLE_CENTRE = Y_W'((GAME_HEIGHT - PADDLE_HEIGHT) / 2);
  localparam logic [SCORE_WIDTH-1:0] SCORE_MAX = SCORE_WIDTH'(SCORE_LIMIT);

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [PCNT_W-1:0]       pcnt_reg;
  logic                    paddle_tick;
  logic [1:0][Y_W-1:0]     paddle_reg, paddle_next;
  logic [1:0]              up_in, down_in, hit;
  logic [X_W-1:0]          ball_x_reg, ball_x_next;
  logic [Y_W-1:0]          ball_y_reg, ball_y_next, ball_y_step;
  logic                    dir_x_reg, dir_x_next;   // 1: moving toward P2 (+x)
  logic                    dir_y_reg, dir_y_next;   // 1: moving down (+y)
  logic [SCORE_WIDTH-1:0]  score_p1_reg, score_p1_next, score_p2_reg, score_p2_next;
  logic [1:0]              winner_reg, winner_next;
  logic                    active_reg;
  logic                    ball_step, point_done, y_flip, dir_y_step, at_p1, at_p2, miss;

  assign paddle_tick = (pcnt_reg == PCNT_W'(PADDLE_SPEED - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || paddle_tick) pcnt_reg <= '0;
    else                      pcnt_reg <= pcnt_reg + 1'b1;
  end

  assign up_in   = {Paddle_Up_P2_i, Paddle_Up_P1_i};
  assign down_in = {Paddle_Down_P2_i, Paddle_Down_P1_i};

  // Index 0 is P1 (column 0), index 1 is P2 (last column).
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_paddle
      logic move_up, move_down;
      assign move_up   = paddle_tick && up_in[gi] && !down_in[gi] && (paddle_reg[gi] != '0);
      assign move_down = paddle_tick && down_in[gi] && !up_in[gi] && (paddle_reg[gi] != PADDLE_MAX);
      assign paddle_next[gi] =
        (state_reg == GAME_OVER) ? (Game_Start_i ? PADDLE_CENTRE : paddle_reg[gi]) :
        move_up                  ? paddle_reg[gi] - 1'b1 :
        move_down                ? paddle_reg[gi] + 1'b1 : paddle_reg[gi];
      assign hit[gi] = (ball_y_reg >= paddle_reg[gi]) &&
                       ({1'b0, ball_y_reg} <= {1'b0, paddle_reg[gi]} + (Y_W+1)'(PADDLE_HEIGHT - 1));
    end
  endgenerate

  // All step decisions use the pre-step ball and paddle registers.
  assign ball_step   = (state_reg == RUNNING) && (cnt_reg == CNT_W'(BALL_SPEED - 1));
  assign point_done  = (state_reg == POINT) && (cnt_reg == CNT_W'(POINT_DELAY - 1));
  assign y_flip      = dir_y_reg ? (ball_y_reg == Y_BOTTOM) : (ball_y_reg == '0);
  assign dir_y_step  = dir_y_reg ^ y_flip;
  assign ball_y_step = dir_y_step ? ball_y_reg + 1'b1 : ball_y_reg - 1'b1;
  assign at_p2       = dir_x_reg && (ball_x_reg == X_NEAR_P2);
  assign at_p1       = !dir_x_reg && (ball_x_reg == X_NEAR_P1);
  assign miss        = (at_p2 && !hit[1]) || (at_p1 && !hit[0]);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (Game_Start_i) state_next = RUNNING;
      RUNNING:   if (ball_step && miss) state_next = POINT;
      POINT:     if (point_done)
                   state_next = (score_p1_reg == SCORE_MAX || score_p2_reg == SCORE_MAX) ? GAME_OVER : IDLE;
      GAME_OVER: if (Game_Start_i) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    cnt_next      = '0;
    ball_x_next   = ball_x_reg;
    ball_y_next   = ball_y_reg;
    dir_x_next    = dir_x_reg;
    dir_y_next    = dir_y_reg;
    score_p1_next = score_p1_reg;
    score_p2_next = score_p2_reg;
    winner_next   = winner_reg;
    case (state_reg)
      IDLE: begin
        ball_x_next = X_CENTRE;
        ball_y_next = Y_CENTRE;
      end
      RUNNING: begin
        if (!ball_step) begin
          cnt_next = cnt_reg + 1'b1;
        end else begin
          ball_y_next = ball_y_step;
          dir_y_next  = dir_y_step;
          if (at_p2 && hit[1]) begin
            dir_x_next  = 1'b0;
            ball_x_next = ball_x_reg - 1'b1;
          end else if (at_p1 && hit[0]) begin
            dir_x_next  = 1'b1;
            ball_x_next = ball_x_reg + 1'b1;
          end else begin
            ball_x_next = dir_x_reg ? ball_x_reg + 1'b1 : ball_x_reg - 1'b1;
            // A miss scores for the opposite player and sets the next serve toward P1 / P2.
            if (at_p2) begin
              score_p1_next = score_p1_reg + 1'b1;
              dir_x_next    = 1'b0;
            end
            if (at_p1) begin
              score_p2_next = score_p2_reg + 1'b1;
              dir_x_next    = 1'b1;
            end
          end
        end
      end
      POINT: begin
        if (!point_done)                  cnt_next    = cnt_reg + 1'b1;
        else if (score_p1_reg == SCORE_MAX) winner_next = 2'b01;
        else if (score_p2_reg == SCORE_MAX) winner_next = 2'b10;
        else begin
          ball_x_next = X_CENTRE;
          ball_y_next = Y_CENTRE;
          dir_y_next  = 1'b1;
        end
      end
      GAME_OVER: begin
        if (Game_Start_i) begin
          score_p1_next = '0;
          score_p2_next = '0;
          winner_next   = 2'b00;
          ball_x_next   = X_CENTRE;
          ball_y_next   = Y_CENTRE;
          dir_x_next    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_reg      <= '0;
      paddle_reg   <= {PADDLE_CENTRE, PADDLE_CENTRE};
      ball_x_reg   <= X_CENTRE;
      ball_y_reg   <= Y_CENTRE;
      dir_x_reg    <= 1'b1;
      dir_y_reg    <= 1'b1;
      score_p1_reg <= '0;
      score_p2_reg <= '0;
      winner_reg   <= 2'b00;
      active_reg   <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      paddle_reg   <= paddle_next;
      ball_x_reg   <= ball_x_next;
      ball_y_reg   <= ball_y_next;
      dir_x_reg    <= dir_x_next;
      dir_y_reg    <= dir_y_next;
      score_p1_reg <= score_p1_next;
      score_p2_reg <= score_p2_next;
      winner_reg   <= winner_next;
      active_reg   <= (state_next == RUNNING);
    end
  end

  assign Ball_X_o      = ball_x_reg;
  assign Ball_Y_o      = ball_y_reg;
  assign Paddle_Y_P1_o = paddle_reg[0];
  assign Paddle_Y_P2_o = paddle_reg[1];
  assign Score_P1_o    = score_p1_reg;
  assign Score_P2_o    = score_p2_reg;
  assign State_o       = state_reg;
  assign Winner_o      = winner_reg;
  assign Ball_Active_o = active_reg;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: hand-computed vector table for the directed scenarios,
// then random play checked every clock against a behavioural game model.
module tb_pong_game_ctrl;

  localparam int W = 8, H = 6, PH = 2, BS = 4, PS = 2, PD = 3, SW = 4, LIM = 2;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic up1 = 1'b0, dn1 = 1'b0, up2 = 1'b0, dn2 = 1'b0;
  logic [2:0] bx, by, p1, p2;
  logic [SW-1:0] s1, s2;
  logic [1:0] st, win;
  logic act;

  always #5 clk = ~clk;

  pong_game_ctrl #(
    .GAME_WIDTH(W), .GAME_HEIGHT(H), .PADDLE_HEIGHT(PH), .BALL_SPEED(BS),
    .PADDLE_SPEED(PS), .POINT_DELAY(PD), .SCORE_WIDTH(SW), .SCORE_LIMIT(LIM)
  ) dut (
    .clk_i(clk), .rst_i(rst), .Game_Start_i(start),
    .Paddle_Up_P1_i(up1), .Paddle_Down_P1_i(dn1),
    .Paddle_Up_P2_i(up2), .Paddle_Down_P2_i(dn2),
    .Ball_X_o(bx), .Ball_Y_o(by), .Paddle_Y_P1_o(p1), .Paddle_Y_P2_o(p2),
    .Score_P1_o(s1), .Score_P2_o(s2), .State_o(st), .Winner_o(win),
    .Ball_Active_o(act)
  );

  int tests = 0, fails = 0;

  // Behavioural model: plain integers, signed directions, edge counting.
  int m_state, m_bx, m_by, m_dx, m_dy, m_t, m_edges, m_win;
  int m_p[2];
  int m_s[2];

  function automatic bit covers(input int p, input int y);
    return (y >= p) && (y < p + PH);
  endfunction

  function automatic void model_reset();
    m_state = 0; m_bx = W / 2; m_by = H / 2; m_dx = 1; m_dy = 1;
    m_t = 0; m_edges = 0; m_win = 0;
    m_p[0] = (H - PH) / 2; m_p[1] = (H - PH) / 2;
    m_s[0] = 0; m_s[1] = 0;
  endfunction

  function automatic void ball_move(input int pp1, input int pp2);
    int oy = m_by;
    int nx = m_bx + m_dx;
    if (m_by + m_dy < 0 || m_by + m_dy > H - 1) m_dy = -m_dy;
    m_by = m_by + m_dy;
    if (nx == W - 1 && covers(pp2, oy)) begin
      m_dx = -1; m_bx = m_bx - 1;
    end else if (nx == 0 && covers(pp1, oy)) begin
      m_dx = 1; m_bx = m_bx + 1;
    end else begin
      m_bx = nx;
      if (nx == W - 1) begin m_s[0]++; m_dx = -1; m_state = 2; m_t = 0; end
      else if (nx == 0) begin m_s[1]++; m_dx = 1; m_state = 2; m_t = 0; end
    end
  endfunction

  function automatic void model_clock(input bit r, input bit s, input bit u1, input bit d1,
                                      input bit u2, input bit d2);
    int op0, op1, prev;
    bit tick;
    bit up[2];
    bit dn[2];
    if (r) begin
      model_reset();
      return;
    end
    m_edges++;
    tick = (m_edges % PS) == 0;
    op0 = m_p[0]; op1 = m_p[1]; prev = m_state;
    up[0] = u1; up[1] = u2; dn[0] = d1; dn[1] = d2;
    case (m_state)
      0: if (s) begin m_state = 1; m_t = 0; end
      1: begin
        m_t++;
        if (m_t == BS) begin m_t = 0; ball_move(op0, op1); end
      end
      2: begin
        m_t++;
        if (m_t == PD) begin
          m_t = 0;
          if (m_s[0] == LIM) begin m_state = 3; m_win = 1; end
          else if (m_s[1] == LIM) begin m_state = 3; m_win = 2; end
          else begin m_state = 0; m_bx = W / 2; m_by = H / 2; m_dy = 1; end
        end
      end
      default: if (s) begin
        m_state = 0; m_s[0] = 0; m_s[1] = 0; m_win = 0;
        m_bx = W / 2; m_by = H / 2; m_dx = 1;
      end
    endcase
    for (int i = 0; i < 2; i++) begin
      if (prev == 3) begin
        if (s) m_p[i] = (H - PH) / 2;
      end else if (tick && up[i] && !dn[i]) m_p[i] = (m_p[i] > 0) ? m_p[i] - 1 : 0;
      else if (tick && dn[i] && !up[i]) m_p[i] = (m_p[i] < H - PH) ? m_p[i] + 1 : H - PH;
    end
  endfunction

  task automatic chk(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  task automatic check_model(input string tag, output bit bad);
    int f0 = fails;
    chk({tag, " state"},  int'(st),  m_state);
    chk({tag, " ball_x"}, int'(bx),  m_bx);
    chk({tag, " ball_y"}, int'(by),  m_by);
    chk({tag, " pad_p1"}, int'(p1),  m_p[0]);
    chk({tag, " pad_p2"}, int'(p2),  m_p[1]);
    chk({tag, " sc_p1"},  int'(s1),  m_s[0]);
    chk({tag, " sc_p2"},  int'(s2),  m_s[1]);
    chk({tag, " winner"}, int'(win), m_win);
    chk({tag, " active"}, int'(act), (m_state == 1) ? 1 : 0);
    bad = (fails != f0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_clock(rst, start, up1, dn1, up2, dn2);
    #1;
  endtask

  typedef struct {
    int rst, start, u1, d1, u2, d2, cyc;
    int st, bx, by, p1, p2, s1, s2, win;
  } vec_t;

  vec_t vq[$];

  initial begin
    bit bad;
    model_reset();
    //            rst st u1 d1 u2 d2 cyc  state bx by p1 p2 s1 s2 win
    vq.push_back('{1, 0, 0, 0, 0, 0, 1,   0, 4, 3, 2, 2, 0, 0, 0});
    vq.push_back('{0, 0, 1, 0, 0, 0, 1,   0, 4, 3, 2, 2, 0, 0, 0});
    vq.push_back('{0, 0, 1, 0, 0, 0, 1,   0, 4, 3, 1, 2, 0, 0, 0});
    vq.push_back('{0, 0, 1, 0, 0, 0, 2,   0, 4, 3, 0, 2, 0, 0, 0});
    vq.push_back('{0, 0, 1, 0, 0, 0, 4,   0, 4, 3, 0, 2, 0, 0, 0});
    vq.push_back('{0, 0, 1, 1, 0, 0, 4,   0, 4, 3, 0, 2, 0, 0, 0});
    vq.push_back('{0, 0, 0, 1, 0, 0, 4,   0, 4, 3, 2, 2, 0, 0, 0});
    vq.push_back('{0, 1, 0, 0, 0, 0, 1,   1, 4, 3, 2, 2, 0, 0, 0});
    vq.push_back('{0, 0, 0, 0, 0, 0, 3,   1, 4, 3, 2, 2, 0, 0, 0});
    vq.push_back('{0, 0, 0, 0, 0, 0, 1,   1, 5, 4, 2, 2, 0, 0, 0});
    vq.push_back('{0, 0, 0, 0, 0, 0, 4,   1, 6, 5, 2, 2, 0, 0, 0});
    vq.push_back('{0, 0, 0, 0, 0, 0, 4,   2, 7, 4, 2, 2, 1, 0, 0});
    vq.push_back('{0, 0, 0, 0, 0, 0, 2,   2, 7, 4, 2, 2, 1, 0, 0});
    vq.push_back('{0, 0, 0, 0, 0, 0, 1,   0, 4, 3, 2, 2, 1, 0, 0});
    vq.push_back('{0, 0, 0, 1, 0, 0, 4,   0, 4, 3, 4, 2, 1, 0, 0});
    vq.push_back('{0, 1, 0, 0, 0, 0, 1,   1, 4, 3, 4, 2, 1, 0, 0});
    vq.push_back('{0, 0, 0, 0, 0, 0, 12,  1, 1, 4, 4, 2, 1, 0, 0});
    vq.push_back('{0, 0, 0, 0, 0, 0, 4,   1, 2, 3, 4, 2, 1, 0, 0});
    vq.push_back('{0, 0, 0, 0, 0, 0, 20,  2, 7, 2, 4, 2, 2, 0, 0});
    vq.push_back('{0, 0, 0, 0, 0, 0, 3,   3, 7, 2, 4, 2, 2, 0, 1});
    vq.push_back('{0, 0, 1, 0, 0, 0, 4,   3, 7, 2, 4, 2, 2, 0, 1});
    vq.push_back('{0, 1, 0, 0, 0, 0, 1,   0, 4, 3, 2, 2, 0, 0, 0});
    vq.push_back('{0, 0, 0, 0, 0, 1, 4,   0, 4, 3, 2, 4, 0, 0, 0});
    vq.push_back('{0, 1, 0, 0, 0, 0, 1,   1, 4, 3, 2, 4, 0, 0, 0});
    vq.push_back('{0, 0, 0, 0, 0, 0, 8,   1, 6, 5, 2, 4, 0, 0, 0});
    vq.push_back('{0, 0, 0, 0, 0, 0, 4,   1, 5, 4, 2, 4, 0, 0, 0});
    vq.push_back('{0, 0, 0, 0, 0, 0, 4,   1, 4, 3, 2, 4, 0, 0, 0});
    vq.push_back('{1, 1, 0, 0, 0, 0, 1,   0, 4, 3, 2, 2, 0, 0, 0});
    vq.push_back('{0, 0, 0, 0, 0, 0, 1,   0, 4, 3, 2, 2, 0, 0, 0});

    // Directed table: inputs held for cyc clocks (rst/start pulse only on the first).
    for (int i = 0; i < vq.size(); i++) begin
      string tag;
      rst = (vq[i].rst != 0); start = (vq[i].start != 0);
      up1 = (vq[i].u1 != 0); dn1 = (vq[i].d1 != 0);
      up2 = (vq[i].u2 != 0); dn2 = (vq[i].d2 != 0);
      for (int c = 0; c < vq[i].cyc; c++) begin
        cycle();
        check_model($sformatf("vec%0d.c%0d model", i, c), bad);
        rst = 1'b0; start = 1'b0;
      end
      tag = $sformatf("vec%0d", i);
      chk({tag, " state"},  int'(st),  vq[i].st);
      chk({tag, " ball_x"}, int'(bx),  vq[i].bx);
      chk({tag, " ball_y"}, int'(by),  vq[i].by);
      chk({tag, " pad_p1"}, int'(p1),  vq[i].p1);
      chk({tag, " pad_p2"}, int'(p2),  vq[i].p2);
      chk({tag, " sc_p1"},  int'(s1),  vq[i].s1);
      chk({tag, " sc_p2"},  int'(s2),  vq[i].s2);
      chk({tag, " winner"}, int'(win), vq[i].win);
      chk({tag, " active"}, int'(act), (vq[i].st == 1) ? 1 : 0);
      $display("[TB] vec %0d: state=%0d ball=(%0d,%0d) paddles=%0d/%0d score=%0d-%0d winner=%0d",
               i, st, bx, by, p1, p2, s1, s2, win);
    end
    up1 = 1'b0; dn1 = 1'b0; up2 = 1'b0; dn2 = 1'b0;

    // Random play against the model; stop at the first divergent cycle.
    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom_range(0, 599) == 0);
      start = ($urandom_range(0, 5) == 0);
      up1 = $urandom_range(0, 1) == 1; dn1 = $urandom_range(0, 1) == 1;
      up2 = $urandom_range(0, 1) == 1; dn2 = $urandom_range(0, 1) == 1;
      cycle();
      check_model($sformatf("rand%0d", n), bad);
      if (bad) break;
      if (n % 250 == 249)
        $display("[TB] rand %0d: state=%0d ball=(%0d,%0d) paddles=%0d/%0d score=%0d-%0d winner=%0d",
                 n, st, bx, by, p1, p2, s1, s2, win);
    end
    rst = 1'b0; start = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
